// File: rtl/sync_fifo_pkg.sv
// rtl/sync_fifo_pkg.sv - shared types and constants for the sync FIFO tile
package sync_fifo_pkg;

  localparam int FIFO_DATA_W = 6;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/sync_fifo_serial_tx_if.sv
// rtl/sync_fifo_serial_tx_if.sv - FIFO read port and serial line bundle for the drain stage
interface sync_fifo_serial_tx_if
  import sync_fifo_pkg::*;
#(
  parameter int DATA_W = FIFO_DATA_W
);

  logic              tx_en;
  logic              fifo_empty;
  logic [DATA_W-1:0] fifo_dat;
  logic              fifo_rd_en;
  logic              tx_o;
  logic              busy;
  logic              frame_done;

  modport master (
    output tx_en, fifo_empty, fifo_dat,
    input  fifo_rd_en, tx_o, busy, frame_done
  );

  modport slave (
    input  tx_en, fifo_empty, fifo_dat,
    output fifo_rd_en, tx_o, busy, frame_done
  );

endinterface

// File: rtl/sync_fifo_baud_tick.sv
// rtl/sync_fifo_baud_tick.sv - bit-period counter; tick marks the last cycle of each serial bit
module sync_fifo_baud_tick #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] TERM = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr || (cnt == TERM)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = (cnt == TERM);

endmodule

// File: rtl/sync_fifo_serial_tx.sv
// rtl/sync_fifo_serial_tx.sv - pulls words from the FIFO and serializes them as start/data/parity/stop frames
module sync_fifo_serial_tx
  import sync_fifo_pkg::*;
#(
  parameter int DATA_W       = FIFO_DATA_W,
  parameter int CLKS_PER_BIT = 4,
  parameter int PARITY_EN    = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  sync_fifo_serial_tx_if.slave bus
);

  localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

  tx_state_t         state;
  tx_state_t         state_nx;
  logic [DATA_W-1:0] shreg;
  logic              par;
  logic [BW-1:0]     bit_idx;
  logic              tick;
  logic              clr;
  logic              line;

  // Both the baud counter and the bit index restart on every state change.
  assign clr = (state_nx != state);

  sync_fifo_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (clr),
    .tick (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (bus.tx_en && !bus.fifo_empty) state_nx = FETCH;
      FETCH:   state_nx = LOAD;
      LOAD:    state_nx = START;
      START:   if (tick) state_nx = DATA;
      DATA:    if (tick && (bit_idx == LAST_BIT)) state_nx = (PARITY_EN != 0) ? PARITY : STOP;
      PARITY:  if (tick) state_nx = STOP;
      STOP:    if (tick) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // The FIFO output register is valid during LOAD, one cycle after the strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg   <= '0;
      par     <= 1'b0;
      bit_idx <= '0;
    end else begin
      if (state == LOAD) begin
        shreg <= bus.fifo_dat;
        par   <= ^bus.fifo_dat;
      end else if ((state == DATA) && tick) begin
        shreg <= shreg >> 1;
      end
      if (clr) begin
        bit_idx <= '0;
      end else if ((state == DATA) && tick) begin
        bit_idx <= bit_idx + 1'b1;
      end
    end
  end

  always_comb begin
    line = LINE_IDLE;
    case (state)
      START:   line = START_BIT;
      DATA:    line = shreg[0];
      PARITY:  line = par;
      STOP:    line = STOP_BIT;
      default: line = LINE_IDLE;
    endcase
  end

  assign bus.tx_o       = line;
  assign bus.fifo_rd_en = (state == FETCH);
  assign bus.busy       = (state != IDLE);
  assign bus.frame_done = (state == STOP) && tick;

endmodule
